// File: rtl/ring_pkg.sv
// Shared definitions for the one-hot ring counter, its encoder and the sequence checker.
//   RING_N        number of ring positions
//   RING_CW       encoded position width (log2 of RING_N)
//   ring_state_e  checker state: IDLE=0, SYNC=1, TRACK=2, FAULT=3
package ring_pkg;

  localparam int unsigned RING_N  = 16;
  localparam int unsigned RING_CW = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSync  = 2'd1,
    StTrack = 2'd2,
    StFault = 2'd3
  } ring_state_e;

endpackage

// File: rtl/ring_sequence_checker_onehot_encoder.sv
// Combinational one-hot to binary encoder with an exactly-one-bit-set flag.
// Ports:
//   q_i          N-bit one-hot candidate
//   idx_o        binary index (OR of the indices of all set bits)
//   onehot_ok_o  high iff exactly one bit of q_i is set
module onehot_encoder
  import ring_pkg::*;
#(
  parameter int unsigned N  = RING_N,
  parameter int unsigned CW = RING_CW
) (
  input  logic [N-1:0]  q_i,
  output logic [CW-1:0] idx_o,
  output logic          onehot_ok_o
);

  logic any_set;
  logic multi_set;

  always_comb begin
    idx_o     = '0;
    any_set   = 1'b0;
    multi_set = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (q_i[i]) begin
        idx_o = idx_o | CW'(i);
      end
      // A second set bit seen after any earlier one marks the input as multi-hot.
      multi_set = multi_set | (any_set & q_i[i]);
      any_set   = any_set | q_i[i];
    end
    onehot_ok_o = any_set & ~multi_set;
  end

endmodule

// File: rtl/ring_sequence_checker.sv
// Checks the output of a one-hot ring counter: encodes each strobed sample, verifies the
// one-hot invariant and the +1 mod N advance, and reports lock status, error pulses and a
// saturating wrap count.
// Ports:
//   CLK, RST    clock; synchronous active-high reset
//   Q, Q_VALID  ring state sample and its strobe
//   C, C_VALID  registered position of last valid sample; pulse when C updates
//   ONEHOT_ERR  pulse: sampled Q did not have exactly one bit set
//   SEQ_ERR     pulse: valid sample broke the sequence while in TRACK
//   LOCKED      STATE == TRACK
//   WRAPS       saturating count of N-1 -> 0 advances seen in TRACK
//   STATE       IDLE=0, SYNC=1, TRACK=2, FAULT=3
// Build option: define RING_ALLOW_HOLD_EN to accept a repeated position (stalled upstream
// counter) in SYNC and TRACK without error or state change.
module ring_sequence_checker
  import ring_pkg::*;
#(
  parameter int unsigned N        = RING_N,
  parameter int unsigned CW       = RING_CW,
  parameter int unsigned LOCK_LEN = 2,
  parameter int unsigned WRAP_W   = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N-1:0]      Q,
  input  logic              Q_VALID,
  output logic [CW-1:0]     C,
  output logic              C_VALID,
  output logic              ONEHOT_ERR,
  output logic              SEQ_ERR,
  output logic              LOCKED,
  output logic [WRAP_W-1:0] WRAPS,
  output logic [1:0]        STATE
);

  localparam int unsigned LW = $clog2(LOCK_LEN + 1);
  localparam logic [LW-1:0] LockLast = LW'(LOCK_LEN - 1);

  ring_state_e       state_q, state_d;
  logic [CW-1:0]     prev_q, prev_d;
  logic [LW-1:0]     lock_q, lock_d;
  logic [CW-1:0]     c_q, c_d;
  logic              c_valid_q, c_valid_d;
  logic              oh_err_q, oh_err_d;
  logic              seq_err_q, seq_err_d;
  logic [WRAP_W-1:0] wraps_q, wraps_d;

  logic [CW-1:0] idx;
  logic          onehot_ok;
  logic          is_next;
  logic          hold_ok;

  onehot_encoder #(
    .N  (N),
    .CW (CW)
  ) u_enc (
    .q_i         (Q),
    .idx_o       (idx),
    .onehot_ok_o (onehot_ok)
  );

  // N is a power of two, so CW-bit wraparound gives the mod N advance.
  assign is_next = (idx == prev_q + CW'(1));

`ifdef RING_ALLOW_HOLD_EN
  assign hold_ok = (idx == prev_q);
`else
  assign hold_ok = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    lock_d    = lock_q;
    c_d       = c_q;
    c_valid_d = 1'b0;
    oh_err_d  = 1'b0;
    seq_err_d = 1'b0;
    wraps_d   = wraps_q;

    if (Q_VALID) begin
      if (!onehot_ok) begin
        // Invalid samples never reach the sequence check.
        oh_err_d = 1'b1;
        unique case (state_q)
          StSync:  state_d = StIdle;
          StTrack: state_d = StFault;
          default: state_d = state_q;
        endcase
      end else begin
        c_d       = idx;
        c_valid_d = 1'b1;
        unique case (state_q)
          StIdle, StFault: begin
            state_d = StSync;
            prev_d  = idx;
            lock_d  = '0;
          end
          StSync: begin
            if (hold_ok) begin
              state_d = StSync;
            end else if (is_next) begin
              prev_d = idx;
              lock_d = lock_q + LW'(1);
              if (lock_q == LockLast) begin
                state_d = StTrack;
              end
            end else begin
              prev_d = idx;
              lock_d = '0;
            end
          end
          StTrack: begin
            if (hold_ok) begin
              state_d = StTrack;
            end else if (is_next) begin
              prev_d = idx;
              if (prev_q == '1 && wraps_q != '1) begin
                wraps_d = wraps_q + WRAP_W'(1);
              end
            end else begin
              seq_err_d = 1'b1;
              state_d   = StFault;
            end
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      prev_q    <= '0;
      lock_q    <= '0;
      c_q       <= '0;
      c_valid_q <= 1'b0;
      oh_err_q  <= 1'b0;
      seq_err_q <= 1'b0;
      wraps_q   <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      lock_q    <= lock_d;
      c_q       <= c_d;
      c_valid_q <= c_valid_d;
      oh_err_q  <= oh_err_d;
      seq_err_q <= seq_err_d;
      wraps_q   <= wraps_d;
    end
  end

  assign C          = c_q;
  assign C_VALID    = c_valid_q;
  assign ONEHOT_ERR = oh_err_q;
  assign SEQ_ERR    = seq_err_q;
  assign LOCKED     = (state_q == StTrack);
  assign WRAPS      = wraps_q;
  assign STATE      = state_q;

endmodule

// File: tb/tb_ring_sequence_checker.sv
// Self-checking bench for ring_sequence_checker: directed scenarios plus randomized
// stimulus, all compared every cycle against a behavioural model of the checker.
module tb_ring_sequence_checker;

  localparam int N        = 16;
  localparam int LOCK_LEN = 2;
  localparam int WRAP_MAX = 255;
`ifdef RING_ALLOW_HOLD_EN
  localparam bit ALLOW_HOLD = 1'b1;
`else
  localparam bit ALLOW_HOLD = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] Q = '0;
  logic        Q_VALID = 1'b0;
  logic [3:0]  C;
  logic        C_VALID;
  logic        ONEHOT_ERR;
  logic        SEQ_ERR;
  logic        LOCKED;
  logic [7:0]  WRAPS;
  logic [1:0]  STATE;

  ring_sequence_checker dut (
    .CLK        (CLK),
    .RST        (RST),
    .Q          (Q),
    .Q_VALID    (Q_VALID),
    .C          (C),
    .C_VALID    (C_VALID),
    .ONEHOT_ERR (ONEHOT_ERR),
    .SEQ_ERR    (SEQ_ERR),
    .LOCKED     (LOCKED),
    .WRAPS      (WRAPS),
    .STATE      (STATE)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: states 0 idle, 1 sync, 2 track, 3 fault.
  int m_state, m_prev, m_lock, m_wraps, m_c, m_cv, m_oe, m_se;

  task automatic model_reset();
    m_state = 0; m_prev = 0; m_lock = 0; m_wraps = 0;
    m_c = 0; m_cv = 0; m_oe = 0; m_se = 0;
  endtask

  task automatic model_step(input bit rst, input bit v, input logic [15:0] q);
    int pos;
    bit nxt, hold;
    if (rst) begin
      model_reset();
      return;
    end
    m_cv = 0; m_oe = 0; m_se = 0;
    if (!v) return;
    if ($countones(q) != 1) begin
      m_oe = 1;
      if (m_state == 1) m_state = 0;
      else if (m_state == 2) m_state = 3;
      return;
    end
    pos = 0;
    for (int i = 0; i < N; i++) if (q[i]) pos = i;
    m_c  = pos;
    m_cv = 1;
    nxt  = (pos == (m_prev + 1) % N);
    hold = ALLOW_HOLD && (pos == m_prev);
    case (m_state)
      0, 3: begin m_state = 1; m_prev = pos; m_lock = 0; end
      1: begin
        if (hold) begin
        end else if (nxt) begin
          m_prev = pos;
          m_lock++;
          if (m_lock >= LOCK_LEN) m_state = 2;
        end else begin
          m_prev = pos; m_lock = 0;
        end
      end
      default: begin
        if (hold) begin
        end else if (nxt) begin
          if (m_prev == N - 1 && m_wraps < WRAP_MAX) m_wraps++;
          m_prev = pos;
        end else begin
          m_se = 1; m_state = 3;
        end
      end
    endcase
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("C", int'(C), m_c);
    chk("C_VALID", int'(C_VALID), m_cv);
    chk("ONEHOT_ERR", int'(ONEHOT_ERR), m_oe);
    chk("SEQ_ERR", int'(SEQ_ERR), m_se);
    chk("LOCKED", int'(LOCKED), (m_state == 2) ? 1 : 0);
    chk("WRAPS", int'(WRAPS), m_wraps);
    chk("STATE", int'(STATE), m_state);
  endtask

  // Drive one cycle, advance the model on the same edge, compare 1 time unit later.
  task automatic step(input bit rst, input bit v, input logic [15:0] q);
    @(negedge CLK);
    RST = rst; Q_VALID = v; Q = q;
    @(posedge CLK);
    model_step(rst, v, q);
    #1;
    compare_all();
  endtask

  task automatic adv(input int pos);
    logic [15:0] one;
    one = 16'd1;
    step(1'b0, 1'b1, one << (pos % N));
  endtask

  int cur;

  initial begin
    model_reset();

    // Reset for two cycles.
    step(1'b1, 1'b1, 16'h0001);
    step(1'b1, 1'b0, 16'h0000);
    chk("reset_state", int'(STATE), 0);
    chk("reset_c", int'(C), 0);

    // Locking: 0,1,2.
    adv(0);
    chk("lock_s0_state", int'(STATE), 1);
    chk("lock_s0_c", int'(C), 0);
    adv(1);
    chk("lock_s1_state", int'(STATE), 1);
    adv(2);
    chk("lock_s2_state", int'(STATE), 2);
    chk("lock_s2_locked", int'(LOCKED), 1);
    chk("lock_s2_c", int'(C), 2);
    chk("lock_s2_cvalid", int'(C_VALID), 1);

    // Wrap counting.
    for (int p = 3; p <= 15; p++) adv(p);
    chk("pre_wrap", int'(WRAPS), 0);
    adv(0);
    chk("wrap_one", int'(WRAPS), 1);

    // Invalid one-hot in TRACK at position 4.
    for (int p = 1; p <= 4; p++) adv(p);
    step(1'b0, 1'b1, 16'h0018);
    chk("oh_multi_err", int'(ONEHOT_ERR), 1);
    chk("oh_multi_state", int'(STATE), 3);
    chk("oh_multi_c", int'(C), 4);
    chk("oh_multi_cvalid", int'(C_VALID), 0);
    step(1'b0, 1'b1, 16'h0000);
    chk("oh_zero_err", int'(ONEHOT_ERR), 1);
    chk("oh_zero_state", int'(STATE), 3);

    // Re-lock at 3,4,5 then skip to 7.
    for (int p = 3; p <= 5; p++) adv(p);
    chk("relock_state", int'(STATE), 2);
    adv(7);
    chk("skip_seq_err", int'(SEQ_ERR), 1);
    chk("skip_state", int'(STATE), 3);
    adv(8);
    chk("rec8_state", int'(STATE), 1);
    adv(9);
    adv(10);
    chk("rec10_state", int'(STATE), 2);
    chk("rec_wraps", int'(WRAPS), 1);

    // Idle strobes with garbage on Q, then a repeated position.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'($urandom));
    chk("idle_c", int'(C), 10);
    chk("idle_cvalid", int'(C_VALID), 0);
    adv(10);
    chk("hold_state", int'(STATE), ALLOW_HOLD ? 2 : 3);
    chk("hold_seq_err", int'(SEQ_ERR), ALLOW_HOLD ? 0 : 1);
    chk("hold_cvalid", int'(C_VALID), 1);

    // Reset mid-operation with WRAPS=3.
    step(1'b1, 1'b0, 16'h0000);
    for (int p = 0; p <= 48; p++) adv(p);
    chk("mid_wraps3", int'(WRAPS), 3);
    step(1'b1, 1'b1, 16'h0002);
    chk("mid_rst_state", int'(STATE), 0);
    chk("mid_rst_wraps", int'(WRAPS), 0);
    chk("mid_rst_c", int'(C), 0);

    // Saturation of the wrap counter.
    for (int p = 0; p <= 4100; p++) adv(p);
    chk("wraps_sat", int'(WRAPS), 255);

    // Randomized traffic.
    step(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [15:0] one;
      one = 16'd1;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        step(1'b1, 1'($urandom), 16'($urandom));
      end else if (r < 12) begin
        step(1'b0, 1'b0, 16'($urandom));
      end else if (r < 70) begin
        cur = (m_prev + 1) % N;
        step(1'b0, 1'b1, one << cur);
      end else if (r < 78) begin
        step(1'b0, 1'b1, one << m_prev);
      end else if (r < 88) begin
        step(1'b0, 1'b1, one << $urandom_range(0, N - 1));
      end else if (r < 93) begin
        step(1'b0, 1'b1, 16'h0000);
      end else begin
        step(1'b0, 1'b1, 16'($urandom) | 16'h0003 << ($urandom_range(0, N - 2)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
